// File: rtl/gen_div_pkg.sv
// Shared definitions for the tone divider bank: default counter width,
// output mode encodings, channel state encoding and a width helper.
package gen_div_pkg;

    localparam int GEN_CNT_W = 32;

    localparam logic MODE_SQUARE = 1'b0;
    localparam logic MODE_PULSE  = 1'b1;

    typedef enum logic {
        CH_IDLE = 1'b0,
        CH_RUN  = 1'b1
    } ch_state_t;

    // Ceiling log2, used to size the channel select.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/gen_div_channel.sv
// One programmable divider channel. The half-period and the mode are
// shadowed and only reloaded at a toggle boundary (or while idle), so a
// new divisor never produces a shortened half-period. Stopping during the
// high half waits for the falling toggle so the high time is never cut.
module gen_div_channel
    import gen_div_pkg::*;
#(
    parameter int CNT_W = GEN_CNT_W
)
(
    input  logic             inclk,
    input  logic             Reset,
    input  logic [CNT_W-1:0] div,
    input  logic             en,
    input  logic             mode,
    output logic             outclk,
    output logic             tick
);

    ch_state_t        state;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] p_act;
    logic             m_act;
    logic             phase;
    logic [CNT_W-1:0] h_last;
    logic             terminal;

    // Last count value of a half-period; a divisor of 0 acts as 1.
    assign h_last   = (p_act == '0) ? '0 : p_act - 1'b1;
    assign terminal = (count >= h_last);

    // Channel state machine: idle shadow loading, counting, toggling, stop.
    always_ff @(posedge inclk or negedge Reset) begin
        if (!Reset) begin
            state  <= CH_IDLE;
            count  <= '0;
            phase  <= 1'b0;
            p_act  <= '0;
            m_act  <= MODE_SQUARE;
            outclk <= 1'b0;
            tick   <= 1'b0;
        end else begin
            tick <= 1'b0;
            case (state)
                CH_IDLE: begin
                    count  <= '0;
                    phase  <= 1'b0;
                    outclk <= 1'b0;
                    p_act  <= div;
                    m_act  <= mode;
                    if (en) begin
                        state <= CH_RUN;
                    end
                end
                CH_RUN: begin
                    if (!en && !phase) begin
                        // Low half: stopping cannot truncate a high pulse.
                        state  <= CH_IDLE;
                        count  <= '0;
                        outclk <= 1'b0;
                    end else if (terminal) begin
                        count <= '0;
                        phase <= ~phase;
                        p_act <= div;
                        m_act <= mode;
                        if (!phase) begin
                            // Rising toggle: high in both modes for this cycle.
                            tick   <= 1'b1;
                            outclk <= 1'b1;
                        end else begin
                            outclk <= 1'b0;
                            if (!en) begin
                                state <= CH_IDLE;
                            end
                        end
                    end else begin
                        count  <= count + 1'b1;
                        outclk <= (m_act == MODE_PULSE) ? 1'b0 : phase;
                    end
                end
                default: begin
                    state  <= CH_IDLE;
                    count  <= '0;
                    phase  <= 1'b0;
                    outclk <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/gen_tone_divider_bank.sv
// Bank of independent tone dividers plus a glitch-free selector that
// routes one channel onto a single registered audio clock. The selector
// only switches while both the current output and the new source are low.
module gen_tone_divider_bank
    import gen_div_pkg::*;
#(
    parameter  int N_CH  = 8,
    parameter  int CNT_W = GEN_CNT_W,
    localparam int SEL_W = clog2(N_CH)
)
(
    input  logic                  inclk,
    input  logic                  Reset,
    input  logic [N_CH*CNT_W-1:0] div_clk_count,
    input  logic [N_CH-1:0]       ch_en,
    input  logic [N_CH-1:0]       mode,
    input  logic [SEL_W-1:0]      sel,
    output logic [N_CH-1:0]       outclk,
    output logic [N_CH-1:0]       tick,
    output logic                  sel_out
);

    logic [SEL_W-1:0] sel_act;
    logic             sel_switch;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        gen_div_channel #(
            .CNT_W (CNT_W)
        ) u_ch (
            .inclk  (inclk),
            .Reset  (Reset),
            .div    (div_clk_count[i*CNT_W +: CNT_W]),
            .en     (ch_en[i]),
            .mode   (mode[i]),
            .outclk (outclk[i]),
            .tick   (tick[i])
        );
    end

    // A pending select change is taken only at a point where it cannot
    // create a short high pulse; out-of-range selects are ignored.
    assign sel_switch = (int'(sel) < N_CH) && (sel != sel_act) &&
                        !sel_out && !outclk[sel];

    // Selector: registered copy of the active channel, switch when safe.
    always_ff @(posedge inclk or negedge Reset) begin
        if (!Reset) begin
            sel_act <= '0;
            sel_out <= 1'b0;
        end else begin
            sel_out <= outclk[sel_act];
            if (sel_switch) begin
                sel_act <= sel;
            end
        end
    end

endmodule
